// File: rtl/kbd_pkg.sv
// Shared types for the keyboard matrix / key-injection block: FSM encoding,
// injection entry layout and the default modifier key positions.
package kbd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRESS = 2'd1,
    GAP   = 2'd2
  } kbd_fsm_t;

  // Spectrum/SAM layout: CAPS SHIFT at row 0 col 0, SYMBOL SHIFT at row 7 col 1
  localparam int KBD_CAPS_ROW = 0;
  localparam int KBD_CAPS_COL = 0;
  localparam int KBD_SYM_ROW  = 7;
  localparam int KBD_SYM_COL  = 1;

  // Entry layout for the default 9x8 matrix; the top slices generically for other sizes
  localparam int KBD_ROW_W = 4;
  localparam int KBD_COL_W = 3;

  typedef struct packed {
    logic [1:0]           mod;
    logic [KBD_ROW_W-1:0] row;
    logic [KBD_COL_W-1:0] col;
  } kbd_entry_t;

endpackage

// File: rtl/kbd_inj_fifo.sv
// Show-ahead synchronous FIFO for queued key injections; flush empties it
// and wins over a simultaneous push or pop.
module kbd_inj_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   flush_i,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic [WIDTH-1:0]       data_i,
  output logic [WIDTH-1:0]       data_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  assign do_push = push_i & ~full_o & ~flush_i;
  assign do_pop  = pop_i & ~empty_o & ~flush_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // pointers wrap naturally because DEPTH is a power of two
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + (AW+1)'(1);
        2'b01:   count_d = count_q - (AW+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/kbd_matrix_inject.sv
// Active-low keyboard matrix merging live key events with a queued
// autotype engine that holds each injected key and its modifiers for a fixed time.
module kbd_matrix_inject
  import kbd_pkg::*;
#(
  parameter int ROWS         = 9,
  parameter int COLS         = 8,
  parameter int FIFO_DEPTH   = 16,
  parameter int HOLD_CYCLES  = 4096,
  parameter int GAP_CYCLES   = 4096,
  parameter int CAPS_ROW     = KBD_CAPS_ROW,
  parameter int CAPS_COL     = KBD_CAPS_COL,
  parameter int SYM_ROW      = KBD_SYM_ROW,
  parameter int SYM_COL      = KBD_SYM_COL,
  parameter bit ABORT_ON_KEY = 1'b1
) (
  input  logic                                       clk_sys,
  input  logic                                       reset,
  input  logic                                       ev_strobe,
  input  logic                                       ev_pressed,
  input  logic [$clog2(ROWS)-1:0]                    ev_row,
  input  logic [$clog2(COLS)-1:0]                    ev_col,
  input  logic                                       clear,
  input  logic                                       inj_valid,
  output logic                                       inj_ready,
  input  logic [$clog2(ROWS)+$clog2(COLS)+1:0]       inj_data,
  output logic                                       inj_busy,
  input  logic [ROWS-1:0]                            row_sel,
  output logic [COLS-1:0]                            key_data,
  output logic                                       anykey,
  output kbd_fsm_t                                   fsm_state,
  output logic [$clog2(FIFO_DEPTH):0]                inj_level
);

  localparam int RW   = $clog2(ROWS);
  localparam int CW   = $clog2(COLS);
  localparam int EW   = RW + CW + 2;
  localparam int CMAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CNTW = $clog2(CMAX) + 1;

  logic [ROWS-1:0][COLS-1:0] live_q, live_d, inj_q, eff, press_mat;
  kbd_fsm_t                  state_q;
  logic [CNTW-1:0]           cnt_q;
  logic                      ev_in_range, abort, flush, push, pop;
  logic                      fifo_full, fifo_empty;
  logic [EW-1:0]             ent;
  logic [1:0]                ent_mod;
  logic [RW-1:0]             ent_row;
  logic [CW-1:0]             ent_col;

  assign ev_in_range = (int'(ev_row) < ROWS) && (int'(ev_col) < COLS);
  assign abort       = ABORT_ON_KEY & ev_strobe & ev_pressed & ev_in_range;
  assign flush       = clear | abort;

  // valid/ready: an entry transfers on a rising clk_sys edge when inj_valid & inj_ready;
  // inj_ready depends only on the registered fill level, never on inj_valid.
  assign inj_ready = ~fifo_full;
  assign push      = inj_valid & ~fifo_full & ~flush;
  assign pop       = (state_q == IDLE) & ~fifo_empty & ~flush;
  assign inj_busy  = ~fifo_empty | (state_q != IDLE);
  assign fsm_state = state_q;

  kbd_inj_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (EW)
  ) u_fifo (
    .clk_i   (clk_sys),
    .rst_i   (reset),
    .flush_i (flush),
    .push_i  (push),
    .pop_i   (pop),
    .data_i  (inj_data),
    .data_o  (ent),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (inj_level)
  );

  assign ent_mod = ent[EW-1 -: 2];
  assign ent_row = ent[CW +: RW];
  assign ent_col = ent[CW-1:0];

  // Out-of-range key positions are skipped, but modifiers and timing still apply
  always_comb begin
    press_mat = '1;
    if ((int'(ent_row) < ROWS) && (int'(ent_col) < COLS)) press_mat[ent_row][ent_col] = 1'b0;
    if (ent_mod[0]) press_mat[CAPS_ROW][CAPS_COL] = 1'b0;
    if (ent_mod[1]) press_mat[SYM_ROW][SYM_COL] = 1'b0;
  end

  always_comb begin
    live_d = live_q;
    if (clear) live_d = '1;
    else if (ev_strobe && ev_in_range) live_d[ev_row][ev_col] = ~ev_pressed;
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) live_q <= '1;
    else       live_q <= live_d;
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      inj_q   <= '1;
    end else if (flush) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      inj_q   <= '1;
    end else begin
      case (state_q)
        IDLE: begin
          if (pop) begin
            state_q <= PRESS;
            cnt_q   <= CNTW'(HOLD_CYCLES - 1);
            inj_q   <= press_mat;
          end
        end
        PRESS: begin
          if (cnt_q == '0) begin
            state_q <= GAP;
            cnt_q   <= CNTW'(GAP_CYCLES - 1);
            inj_q   <= '1;
          end else begin
            cnt_q <= cnt_q - CNTW'(1);
          end
        end
        GAP: begin
          if (cnt_q == '0) state_q <= IDLE;
          else             cnt_q   <= cnt_q - CNTW'(1);
        end
        default: begin
          state_q <= IDLE;
          inj_q   <= '1;
        end
      endcase
    end
  end

  // Injected and live keys AND together: a key reads up only when both release it
  assign eff = live_q & inj_q;

  always_comb begin
    key_data = '1;
    for (int r = 0; r < ROWS; r++) begin
      if (!row_sel[r]) key_data &= eff[r];
    end
  end

  assign anykey = ~&eff;

endmodule

// File: tb/tb_kbd_matrix_inject.sv
// Directed bench for kbd_matrix_inject: 9x8 matrix, hold 4, gap 3, queue depth 4.
module tb_kbd_matrix_inject;
  import kbd_pkg::*;

  logic       clk_sys = 1'b0;
  logic       reset;
  logic       ev_strobe, ev_pressed;
  logic [3:0] ev_row;
  logic [2:0] ev_col;
  logic       clear;
  logic       inj_valid, inj_ready;
  logic [8:0] inj_data;
  logic       inj_busy;
  logic [8:0] row_sel;
  logic [7:0] key_data;
  logic       anykey;
  kbd_fsm_t   fsm_state;
  logic [2:0] inj_level;

  int n_vec = 0;
  int n_err = 0;

  kbd_matrix_inject #(
    .ROWS        (9),
    .COLS        (8),
    .FIFO_DEPTH  (4),
    .HOLD_CYCLES (4),
    .GAP_CYCLES  (3)
  ) dut (
    .clk_sys    (clk_sys),
    .reset      (reset),
    .ev_strobe  (ev_strobe),
    .ev_pressed (ev_pressed),
    .ev_row     (ev_row),
    .ev_col     (ev_col),
    .clear      (clear),
    .inj_valid  (inj_valid),
    .inj_ready  (inj_ready),
    .inj_data   (inj_data),
    .inj_busy   (inj_busy),
    .row_sel    (row_sel),
    .key_data   (key_data),
    .anykey     (anykey),
    .fsm_state  (fsm_state),
    .inj_level  (inj_level)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  function automatic logic [8:0] mk(input logic [1:0] m, input logic [3:0] r, input logic [2:0] c);
    kbd_entry_t e;
    e.mod = m;
    e.row = r;
    e.col = c;
    return e;
  endfunction

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chkn(input string tag, input int obs, input int exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    logic [7:0] one;
    logic [7:0] exp;
    one        = 8'h01;
    reset      = 1'b1;
    ev_strobe  = 1'b0;
    ev_pressed = 1'b0;
    ev_row     = '0;
    ev_col     = '0;
    clear      = 1'b0;
    inj_valid  = 1'b0;
    inj_data   = '0;
    row_sel    = 9'h000;
    tick();
    tick();
    chk8("rst_key_data", key_data, 8'hFF);
    chk1("rst_anykey", anykey, 1'b0);
    chk1("rst_inj_ready", inj_ready, 1'b1);
    chk1("rst_inj_busy", inj_busy, 1'b0);
    chkn("rst_state", int'(fsm_state), int'(IDLE));
    reset = 1'b0;
    tick();

    // live press / release, row 3 col 2
    row_sel = 9'h1F7;
    ev_strobe = 1'b1; ev_pressed = 1'b1; ev_row = 4'd3; ev_col = 3'd2;
    #1;
    chk8("t1_before_edge", key_data, 8'hFF);
    tick();
    ev_strobe = 1'b0;
    chk8("t1_press", key_data, 8'hFB);
    chk1("t1_anykey", anykey, 1'b1);
    row_sel = 9'h1FF;
    #1;
    chk8("t1_no_row_sel", key_data, 8'hFF);
    chk1("t1_anykey_unsel", anykey, 1'b1);
    row_sel = 9'h1F7;
    ev_strobe = 1'b1; ev_pressed = 1'b0;
    tick();
    ev_strobe = 1'b0;
    chk8("t1_release", key_data, 8'hFF);
    chk1("t1_anykey_rel", anykey, 1'b0);
    ev_strobe = 1'b1; ev_pressed = 1'b1; ev_row = 4'd9; ev_col = 3'd0;
    tick();
    ev_strobe = 1'b0;
    chk1("t1_oor_ignored", anykey, 1'b0);

    // single injection with CAPS: row 0 and row 2 selected
    row_sel = 9'h1FA;
    inj_data = mk(2'b01, 4'd2, 3'd7); inj_valid = 1'b1;
    tick();
    inj_valid = 1'b0;
    chk8("t2_after_push", key_data, 8'hFF);
    chk1("t2_busy_queued", inj_busy, 1'b1);
    tick();
    chk8("t2_hold0", key_data, 8'h7E);
    chkn("t2_state_press", int'(fsm_state), int'(PRESS));
    for (int i = 0; i < 3; i++) begin
      tick();
      chk8("t2_hold", key_data, 8'h7E);
    end
    tick();
    chk8("t2_released", key_data, 8'hFF);
    chkn("t2_state_gap", int'(fsm_state), int'(GAP));
    for (int i = 0; i < 2; i++) begin
      tick();
      chk1("t2_busy_gap", inj_busy, 1'b1);
    end
    tick();
    chk1("t2_busy_done", inj_busy, 1'b0);
    chkn("t2_state_idle", int'(fsm_state), int'(IDLE));

    // five back-to-back pushes on row 4; first pops during the second push
    row_sel = 9'h1EF;
    for (int k = 0; k < 5; k++) begin
      inj_data = mk(2'b00, 4'd4, 3'(k)); inj_valid = 1'b1;
      chk1("t3_ready_push", inj_ready, 1'b1);
      tick();
    end
    inj_valid = 1'b0;
    chk1("t3_full_ready", inj_ready, 1'b0);
    chkn("t3_level_full", int'(inj_level), 4);
    for (int t = 3; t < 40; t++) begin
      if (t > 3) tick();
      exp = ((t % 8) < 4) ? ~(one << (t / 8)) : 8'hFF;
      chk8("t3_replay", key_data, exp);
      if (t == 7) begin
        inj_data = mk(2'b00, 4'd4, 3'd7); inj_valid = 1'b1;
        chk1("t3_full_pop_refuse", inj_ready, 1'b0);
      end
      if (t == 8) begin
        inj_valid = 1'b0;
        chkn("t3_level_after_pop", int'(inj_level), 3);
      end
      if (t == 38) chk1("t3_busy_last_gap", inj_busy, 1'b1);
    end
    chk1("t3_busy_end", inj_busy, 1'b0);

    // live press aborts a running injection; out-of-range press does not
    row_sel = 9'h15F;
    inj_data = mk(2'b00, 4'd5, 3'd3); inj_valid = 1'b1;
    tick();
    inj_data = mk(2'b00, 4'd5, 3'd4);
    tick();
    inj_valid = 1'b0;
    chk8("t4_inj_down", key_data, 8'hF7);
    chkn("t4_level", int'(inj_level), 1);
    ev_strobe = 1'b1; ev_pressed = 1'b1; ev_row = 4'd10; ev_col = 3'd0;
    tick();
    ev_strobe = 1'b0;
    chk8("t4_oor_no_abort", key_data, 8'hF7);
    chkn("t4_state_press", int'(fsm_state), int'(PRESS));
    ev_strobe = 1'b1; ev_row = 4'd7; ev_col = 3'd0;
    tick();
    ev_strobe = 1'b0;
    chk8("t4_abort_key", key_data, 8'hFE);
    chk1("t4_abort_busy", inj_busy, 1'b0);
    chkn("t4_abort_level", int'(inj_level), 0);
    chkn("t4_abort_state", int'(fsm_state), int'(IDLE));
    repeat (8) tick();
    chk8("t4_no_replay", key_data, 8'hFE);
    ev_strobe = 1'b1; ev_pressed = 1'b0;
    tick();
    ev_strobe = 1'b0;
    chk8("t4_live_rel", key_data, 8'hFF);

    // live and injected on row 1 col 1; live releases first
    row_sel = 9'h1FD;
    ev_strobe = 1'b1; ev_pressed = 1'b1; ev_row = 4'd1; ev_col = 3'd1;
    tick();
    ev_strobe = 1'b0;
    chk8("t5_live_down", key_data, 8'hFD);
    inj_data = mk(2'b00, 4'd1, 3'd1); inj_valid = 1'b1;
    tick();
    inj_valid = 1'b0;
    tick();
    chk8("t5_both_down", key_data, 8'hFD);
    ev_strobe = 1'b1; ev_pressed = 1'b0;
    tick();
    ev_strobe = 1'b0;
    chk8("t5_live_up_inj_held", key_data, 8'hFD);
    tick();
    tick();
    chk8("t5_hold_last", key_data, 8'hFD);
    tick();
    chk8("t5_both_up", key_data, 8'hFF);
    chk1("t5_anykey", anykey, 1'b0);
    repeat (3) tick();

    // asynchronous reset mid-hold
    row_sel = 9'h1BF;
    inj_data = mk(2'b00, 4'd6, 3'd6); inj_valid = 1'b1;
    tick();
    inj_data = mk(2'b00, 4'd6, 3'd5);
    tick();
    inj_valid = 1'b0;
    tick();
    chk8("t6_held", key_data, 8'hBF);
    #2;
    reset = 1'b1;
    #1;
    chk8("t6_async_key", key_data, 8'hFF);
    chk1("t6_async_anykey", anykey, 1'b0);
    chk1("t6_async_busy", inj_busy, 1'b0);
    chkn("t6_async_level", int'(inj_level), 0);
    chk1("t6_async_ready", inj_ready, 1'b1);
    tick();
    reset = 1'b0;
    repeat (6) tick();
    chk8("t6_post_reset", key_data, 8'hFF);
    chkn("t6_post_state", int'(fsm_state), int'(IDLE));

    // clear beats a coincident push and live press
    ev_strobe = 1'b1; ev_pressed = 1'b1; ev_row = 4'd6; ev_col = 3'd0;
    tick();
    ev_strobe = 1'b0;
    chk8("t6_live_down", key_data, 8'hFE);
    inj_data = mk(2'b00, 4'd6, 3'd6); inj_valid = 1'b1;
    tick();
    inj_valid = 1'b0;
    tick();
    chk8("t6_merged", key_data, 8'hBE);
    clear = 1'b1;
    inj_data = mk(2'b00, 4'd6, 3'd5); inj_valid = 1'b1;
    ev_strobe = 1'b1; ev_pressed = 1'b1; ev_row = 4'd6; ev_col = 3'd1;
    tick();
    clear = 1'b0; inj_valid = 1'b0; ev_strobe = 1'b0;
    chk8("t6_clear_key", key_data, 8'hFF);
    chk1("t6_clear_anykey", anykey, 1'b0);
    chk1("t6_clear_busy", inj_busy, 1'b0);
    chkn("t6_clear_level", int'(inj_level), 0);
    chk1("t6_clear_ready", inj_ready, 1'b1);
    repeat (10) tick();
    chk8("t6_push_absent", key_data, 8'hFF);
    chk1("t6_idle_busy", inj_busy, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
